stack_alu_datapath: RTL

Parametrised successor of the accumulator-style stack datapath. It holds an internal operand stack and executes one command at a time from a valid/ready command port: push immediate, push from memory, pop to memory, and binary/unary ALU ops on the stack top. A synchronous data memory is driven through an explicit read/write port, and flags plus error status are registered. It sits between the control unit (command issuer) and data memory.

---
 rtl/stack_alu_datapath.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/stack_alu_datapath.sv
// Operand-stack datapath: executes one command at a time from a valid/ready port,
// running ALU ops on the stack top and moving words to/from a synchronous data memory.
module stack_alu_datapath #(
    parameter int WORD_RANGE       = 8,
    parameter int STACK_WORD_COUNT = 8,
    parameter int DEPTH_RANGE      = $clog2(STACK_WORD_COUNT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [WORD_RANGE-1:0]  cmd_data,
    output logic [WORD_RANGE-1:0]  mem_addr,
    output logic                   mem_re,
    output logic                   mem_we,
    output logic [WORD_RANGE-1:0]  mem_wdata,
    input  logic [WORD_RANGE-1:0]  mem_rdata,
    output logic [WORD_RANGE-1:0]  stack_top,
    output logic [DEPTH_RANGE-1:0] stack_depth,
    output logic [2:0]             flags,
    output logic                   done,
    output logic [1:0]             error
);
    localparam int IDX_W = (STACK_WORD_COUNT > 1) ? $clog2(STACK_WORD_COUNT) : 1;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_PUSH_IMM = 3'd1;
    localparam logic [2:0] OP_PUSH_MEM = 3'd2;
    localparam logic [2:0] OP_POP_MEM  = 3'd3;
    localparam logic [2:0] OP_ADD      = 3'd4;
    localparam logic [2:0] OP_SUB      = 3'd5;
    localparam logic [2:0] OP_AND      = 3'd6;
    localparam logic [2:0] OP_NOT      = 3'd7;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_OVF = 2'b01;
    localparam logic [1:0] ERR_UNF = 2'b10;

    localparam logic [DEPTH_RANGE-1:0] DEPTH_FULL = DEPTH_RANGE'(STACK_WORD_COUNT);
    localparam logic [DEPTH_RANGE-1:0] DEPTH_ONE  = DEPTH_RANGE'(1);
    localparam logic [DEPTH_RANGE-1:0] DEPTH_TWO  = DEPTH_RANGE'(2);

    typedef enum logic [2:0] {IDLE, EXEC, MEM_RD, MEM_WAIT, DONE} state_t;

    // Returns {carry, result}; carry is only meaningful for ADD/SUB.
    function automatic logic [WORD_RANGE:0] alu_eval(input logic [2:0]            op,
                                                     input logic [WORD_RANGE-1:0] a,
                                                     input logic [WORD_RANGE-1:0] b);
        logic [WORD_RANGE:0] r;
        case (op)
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + {{WORD_RANGE{1'b0}}, 1'b1};
            OP_AND:  r = {1'b0, a & b};
            default: r = {1'b0, ~b};
        endcase
        return r;
    endfunction

    state_t                 state_q, state_d;
    logic [2:0]             op_q, op_d;
    logic [WORD_RANGE-1:0]  arg_q, arg_d;
    logic [DEPTH_RANGE-1:0] depth_q, depth_d;
    logic [2:0]             flags_q, flags_d;
    logic [1:0]             error_q, error_d;
    logic [WORD_RANGE-1:0]  stack_q [STACK_WORD_COUNT];

    logic                  stack_we;
    logic [IDX_W-1:0]      stack_widx;
    logic [WORD_RANGE-1:0] stack_wdata;
    logic [IDX_W-1:0]      top_idx, below_idx;
    logic [WORD_RANGE-1:0] a_word, b_word;
    logic [WORD_RANGE:0]   alu_out;
    logic [2:0]            alu_flags;
    logic [1:0]            op_err;
    logic                  accept, rd_phase, wr_phase;

    assign top_idx   = IDX_W'(depth_q - DEPTH_ONE);
    assign below_idx = IDX_W'(depth_q - DEPTH_TWO);
    assign b_word    = stack_q[top_idx];
    assign a_word    = stack_q[below_idx];
    assign alu_out   = alu_eval(op_q, a_word, b_word);
    assign alu_flags = {alu_out[WORD_RANGE], alu_out[WORD_RANGE-1],
                        alu_out[WORD_RANGE-1:0] == '0};

    assign cmd_ready   = (state_q == IDLE) || (state_q == DONE);
    assign accept      = cmd_valid && cmd_ready;
    assign done        = (state_q == DONE);
    assign stack_top   = (depth_q == '0) ? '0 : b_word;
    assign stack_depth = depth_q;
    assign flags       = flags_q;
    assign error       = error_q;

    always_comb begin
        op_err = ERR_OK;
        case (op_q)
            OP_PUSH_IMM, OP_PUSH_MEM: if (depth_q == DEPTH_FULL) op_err = ERR_OVF;
            OP_POP_MEM, OP_NOT:       if (depth_q == '0) op_err = ERR_UNF;
            OP_ADD, OP_SUB, OP_AND:   if (depth_q < DEPTH_TWO) op_err = ERR_UNF;
            default:                  op_err = ERR_OK;
        endcase
    end

    // Reset masks the strobes combinationally so a mid-command reset never writes memory.
    assign rd_phase  = (state_q == MEM_RD);
    assign wr_phase  = (state_q == EXEC) && (op_q == OP_POP_MEM) && (op_err == ERR_OK);
    assign mem_re    = rd_phase && !reset;
    assign mem_we    = wr_phase && !reset;
    assign mem_addr  = (mem_re || mem_we) ? arg_q : '0;
    assign mem_wdata = mem_we ? b_word : '0;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        arg_d       = arg_q;
        depth_d     = depth_q;
        flags_d     = flags_q;
        error_d     = error_q;
        stack_we    = 1'b0;
        stack_widx  = top_idx;
        stack_wdata = alu_out[WORD_RANGE-1:0];
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    op_d    = cmd_op;
                    arg_d   = cmd_data;
                    error_d = ERR_OK;
                    state_d = (cmd_op == OP_PUSH_MEM) ? MEM_RD : EXEC;
                end
            end
            EXEC: begin
                state_d = DONE;
                error_d = op_err;
                if (op_err == ERR_OK) begin
                    case (op_q)
                        OP_PUSH_IMM: begin
                            stack_we    = 1'b1;
                            stack_widx  = IDX_W'(depth_q);
                            stack_wdata = arg_q;
                            depth_d     = depth_q + DEPTH_ONE;
                        end
                        OP_POP_MEM: depth_d = depth_q - DEPTH_ONE;
                        OP_ADD, OP_SUB, OP_AND: begin
                            stack_we   = 1'b1;
                            stack_widx = below_idx;
                            depth_d    = depth_q - DEPTH_ONE;
                            flags_d    = alu_flags;
                        end
                        OP_NOT: begin
                            stack_we = 1'b1;
                            flags_d  = alu_flags;
                        end
                        default: depth_d = depth_q;
                    endcase
                end
            end
            MEM_RD: state_d = MEM_WAIT;
            MEM_WAIT: begin
                state_d = DONE;
                error_d = op_err;
                if (op_err == ERR_OK) begin
                    stack_we    = 1'b1;
                    stack_widx  = IDX_W'(depth_q);
                    stack_wdata = mem_rdata;
                    depth_d     = depth_q + DEPTH_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            arg_q   <= '0;
            depth_q <= '0;
            flags_q <= '0;
            error_q <= ERR_OK;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            arg_q   <= arg_d;
            depth_q <= depth_d;
            flags_q <= flags_d;
            error_q <= error_d;
        end
    end

    // Stack storage is not reset; depth alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (stack_we && !reset) stack_q[stack_widx] <= stack_wdata;
    end
endmodule
